// File: rtl/flash_bitstream_reader_pkg.sv
// Shared definitions for the flash bitstream reader: FSM states, the flash READ
// opcode and the CRC-32 constants used by the optional CRC sub-module.
package flash_bitstream_reader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ARMED,
    ST_CMD,
    ST_DATA,
    ST_FINISH
  } state_t;

  localparam logic [7:0]  FLASH_READ_OPCODE = 8'h03;
  localparam logic [4:0]  CMD_LAST_BIT      = 5'd31;
  localparam logic [31:0] CRC32_POLY        = 32'h04C11DB7;
  localparam logic [31:0] CRC32_INIT        = 32'hFFFFFFFF;

  // One MSB-first, non-reflected CRC-32 step for a single input bit.
  function automatic logic [31:0] crc32_step(input logic [31:0] crc, input logic bit_in);
    return {crc[30:0], 1'b0} ^ ((crc[31] ^ bit_in) ? CRC32_POLY : 32'h0);
  endfunction

endpackage

// File: rtl/flash_bitstream_reader_crc32.sv
// Bit-serial CRC-32 accumulator; clear restarts it from the init value.
module bitstream_crc32
  import flash_bitstream_reader_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        clear,
  input  logic        bit_en,
  input  logic        bit_in,
  output logic [31:0] crc
);

  logic [31:0] r_crc;

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      r_crc <= CRC32_INIT;
    end else if (bit_en) begin
      r_crc <= crc32_step(r_crc, bit_in);
    end
  end

  assign crc = r_crc;

endmodule

// File: rtl/flash_bitstream_reader.sv
// Streams a channel bitstream out of SPI flash with a READ (0x03) command.
// Define BITSTREAM_CRC_EN to add a running CRC-32 over the streamed data bits.
module flash_bitstream_reader
  import flash_bitstream_reader_pkg::*;
#(
  parameter logic [23:0] START_ADDR     = 24'hCE0000,
  parameter logic [31:0] BITSTREAM_BITS = 32'd31_470_496
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        prog_chan_in_progress,
  input  logic        store_flash_command,
  input  logic        read_bitstream,
  output logic        bitstream,
  output logic        end_bitstream,
  output logic        spi_cs_n,
  output logic        spi_sck,
  output logic        spi_mosi,
  input  logic        spi_miso,
  output logic [31:0] crc_out,
  output logic        crc_valid
);

  state_t      r_state;
  state_t      w_state_next;
  logic [31:0] r_shift;
  logic [31:0] r_bit_cnt;
  logic [4:0]  r_cmd_cnt;
  logic        r_cs_n;
  logic        r_sck_en;
  logic        r_mosi;
  logic        r_bitstream;
  logic        r_end;
  logic        w_keep;
  logic        w_load;
  logic        w_sample;
  logic        w_last;
  logic        w_spi_active;

  assign w_keep = prog_chan_in_progress && read_bitstream;

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (store_flash_command && prog_chan_in_progress) w_state_next = ST_ARMED;
      end
      ST_ARMED: begin
        if (!prog_chan_in_progress) w_state_next = ST_IDLE;
        else if (read_bitstream)    w_state_next = ST_CMD;
      end
      ST_CMD: begin
        if (!w_keep)                          w_state_next = ST_IDLE;
        else if (r_cmd_cnt == CMD_LAST_BIT)   w_state_next = ST_DATA;
      end
      // DATA lingers one cycle after the final sample so the last bit and its
      // end pulse are presented while chip select is still low.
      ST_DATA: begin
        if (!w_keep)     w_state_next = ST_IDLE;
        else if (r_end)  w_state_next = ST_FINISH;
      end
      ST_FINISH: begin
        if (!w_keep) w_state_next = ST_IDLE;
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  assign w_load       = (r_state == ST_IDLE) && store_flash_command && prog_chan_in_progress;
  assign w_sample     = (r_state == ST_DATA) && (w_state_next == ST_DATA);
  assign w_last       = w_sample && (r_bit_cnt == BITSTREAM_BITS - 32'd1);
  assign w_spi_active = (w_state_next == ST_CMD) || (w_state_next == ST_DATA);

  always_ff @(posedge clk) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_state_next;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_shift     <= 32'h0;
      r_cmd_cnt   <= 5'd0;
      r_bit_cnt   <= 32'd0;
      r_cs_n      <= 1'b1;
      r_sck_en    <= 1'b0;
      r_mosi      <= 1'b0;
      r_bitstream <= 1'b1;
      r_end       <= 1'b0;
    end else begin
      r_cs_n   <= ~w_spi_active;
      r_sck_en <= w_spi_active;
      r_end    <= w_last;

      if (w_load) begin
        r_shift <= {FLASH_READ_OPCODE, START_ADDR};
      end else if (w_state_next == ST_CMD) begin
        r_shift <= {r_shift[30:0], 1'b0};
      end
      r_mosi <= (w_state_next == ST_CMD) ? r_shift[31] : 1'b0;

      if ((r_state == ST_CMD) && (w_state_next == ST_CMD)) r_cmd_cnt <= r_cmd_cnt + 5'd1;
      else                                                 r_cmd_cnt <= 5'd0;

      r_bit_cnt <= w_sample ? r_bit_cnt + 32'd1 : 32'd0;

      if (w_sample)                      r_bitstream <= spi_miso;
      else if (w_state_next != ST_DATA)  r_bitstream <= 1'b1;
    end
  end

  assign bitstream     = r_bitstream;
  assign end_bitstream = r_end;
  assign spi_cs_n      = r_cs_n;
  assign spi_mosi      = r_mosi;
  assign spi_sck       = r_sck_en & ~clk;

`ifdef BITSTREAM_CRC_EN
  logic r_crc_valid;

  bitstream_crc32 u_crc (
    .clk    (clk),
    .reset  (reset),
    .clear  (w_load),
    .bit_en (w_sample),
    .bit_in (spi_miso),
    .crc    (crc_out)
  );

  always_ff @(posedge clk) begin
    if (reset || w_load) r_crc_valid <= 1'b0;
    else if (w_last)     r_crc_valid <= 1'b1;
  end

  assign crc_valid = r_crc_valid;
`else
  assign crc_out   = 32'h0;
  assign crc_valid = 1'b0;
`endif

endmodule

// File: tb/tb_flash_bitstream_reader.sv
// Self-checking bench for flash_bitstream_reader: table-driven and randomized
// transfers against a cycle-numbered model of the SPI read sequence.
module tb_flash_bitstream_reader;

  localparam logic [23:0] ADDR     = 24'hCE0000;
  localparam int          NB       = 16;
  localparam logic [31:0] CMD_WORD = {8'h03, ADDR};
`ifdef BITSTREAM_CRC_EN
  localparam bit CRC_EN = 1'b1;
`else
  localparam bit CRC_EN = 1'b0;
`endif
  localparam logic [31:0] CRC_RST = CRC_EN ? 32'hFFFFFFFF : 32'h0;

  logic        clk = 1'b0;
  logic        reset, prog, store, rd, miso;
  logic        bitstream, end_bs, cs_n, sck, mosi, crc_valid;
  logic [31:0] crc_out;

  int checks = 0;
  int errors = 0;
  int end_cnt = 0;
  int sck_cnt = 0;

  typedef struct {
    logic [NB-1:0] data;
    int            stop_at;   // data bits seen before the abort; >= NB means complete
    int            kind;      // 0 drop read_bitstream, 1 drop prog_chan, 2 reset
    int            exp_ends;
  } vec_t;

  vec_t vecs[6];

  flash_bitstream_reader #(
    .START_ADDR     (ADDR),
    .BITSTREAM_BITS (32'(NB))
  ) dut (
    .clk                   (clk),
    .reset                 (reset),
    .prog_chan_in_progress (prog),
    .store_flash_command   (store),
    .read_bitstream        (rd),
    .bitstream             (bitstream),
    .end_bitstream         (end_bs),
    .spi_cs_n              (cs_n),
    .spi_sck               (sck),
    .spi_mosi              (mosi),
    .spi_miso              (miso),
    .crc_out               (crc_out),
    .crc_valid             (crc_valid)
  );

  always #5 clk = ~clk;
  always @(negedge clk) if (end_bs === 1'b1) end_cnt++;
  always @(posedge sck) sck_cnt++;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at t=%0t", name, act, exp, $time);
    end
  endtask

  // CRC as polynomial remainder: (init * x^n + msg * x^32) mod P.
  function automatic logic [31:0] crc_model(input logic [31:0] msg, input int n);
    logic [63:0] v;
    v = (64'hFFFFFFFF << n) ^ ({32'h0, msg} << 32);
    for (int i = 63; i >= 32; i--)
      if (v[i]) v = v ^ (64'h1_04C11DB7 << (i - 32));
    return v[31:0];
  endfunction

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_cs_n"}, cs_n, 1);
    chk({tag, "_sck"}, sck, 0);
    chk({tag, "_mosi"}, mosi, 0);
    chk({tag, "_bitstream"}, bitstream, 1);
    chk({tag, "_end"}, end_bs, 0);
    chk({tag, "_crc_out"}, crc_out, CRC_RST);
    chk({tag, "_crc_valid"}, crc_valid, 0);
  endtask

  task automatic transfer(input logic [NB-1:0] data, input int stop_at, input int kind,
                          input int exp_ends, input string tag);
    int          e0, s0, err0;
    bit          q[$];
    logic [31:0] cw;
    bit          aborted;
    cw = CMD_WORD;
    e0 = end_cnt;
    err0 = errors;
    aborted = 1'b0;
    for (int i = 0; i < NB; i++) q.push_back(data[NB-1-i]);

    prog = 1'b1; rd = 1'b0; store = 1'b1;
    step();
    store = 1'b0;
    chk("armed_cs_n", cs_n, 1);
    chk("armed_crc_valid", crc_valid, 0);

    rd = 1'b1;
    s0 = sck_cnt;
    for (int k = 1; k <= 32; k++) begin
      step();
      chk("cmd_cs_n", cs_n, 0);
      chk("cmd_mosi", mosi, cw[32-k]);
      chk("cmd_bitstream", bitstream, 1);
    end
    step();
    chk("c33_mosi", mosi, 0);
    chk("c33_cs_n", cs_n, 0);
    chk("c33_bitstream", bitstream, 1);
    chk("cmd_sck_count", sck_cnt - s0, 32);

    for (int i = 0; i < NB && !aborted; i++) begin
      miso = data[NB-1-i];
      step();
      chk("data_bit", bitstream, q.pop_front());
      chk("end_pulse", end_bs, (i == NB - 1));
      chk("data_cs_n", cs_n, 0);
      if (i + 1 == stop_at && stop_at < NB) begin
        if (kind == 0)      rd = 1'b0;
        else if (kind == 1) prog = 1'b0;
        else                reset = 1'b1;
        step();
        if (kind == 2) begin
          chk_reset_vals("rst_mid");
        end else begin
          chk("abort_cs_n", cs_n, 1);
          chk("abort_bitstream", bitstream, 1);
          chk("abort_end", end_bs, 0);
        end
        reset = 1'b0; prog = 1'b1; rd = 1'b0;
        aborted = 1'b1;
      end
    end

    if (!aborted) begin
      step();
      chk("fin_cs_n", cs_n, 1);
      chk("fin_bitstream", bitstream, 1);
      chk("fin_end", end_bs, 0);
      chk("fin_crc_valid", crc_valid, CRC_EN ? 32'd1 : 32'd0);
      chk("fin_crc_out", crc_out, CRC_EN ? crc_model({16'h0, data}, NB) : 32'h0);
      for (int k = 0; k < 3; k++) begin
        step();
        chk("finish_hold_cs_n", cs_n, 1);
      end
      rd = 1'b0;
      step();
    end

    for (int k = 0; k < 3; k++) step();
    chk("end_count", end_cnt - e0, exp_ends);
    chk("idle_cs_n", cs_n, 1);
    $display("XFER %s data=%h stop=%0d kind=%0d ends=%0d new_errors=%0d",
             tag, data, stop_at, kind, end_cnt - e0, errors - err0);
  endtask

  initial begin
    int s0;
    reset = 1'b1; prog = 1'b0; store = 1'b0; rd = 1'b0; miso = 1'b0;

    step();
    step();
    chk_reset_vals("reset");
    reset = 1'b0;
    step();
    chk_reset_vals("post_reset");
    $display("XFER reset done");

    // Store without prog_chan_in_progress must not arm the reader.
    s0 = sck_cnt;
    prog = 1'b0; store = 1'b1;
    step();
    store = 1'b0; prog = 1'b1; rd = 1'b1;
    for (int k = 0; k < 40; k++) begin
      step();
      chk("gate_cs_n", cs_n, 1);
      chk("gate_mosi", mosi, 0);
    end
    chk("gate_sck_count", sck_cnt - s0, 0);
    rd = 1'b0;
    step();
    $display("XFER gating done");

    vecs[0] = '{data: 16'hA5C3, stop_at: NB, kind: 0, exp_ends: 1};
    vecs[1] = '{data: 16'hA5C3, stop_at: 5,  kind: 0, exp_ends: 0};
    vecs[2] = '{data: 16'hA5C3, stop_at: NB, kind: 0, exp_ends: 1};
    vecs[3] = '{data: 16'h1234, stop_at: 9,  kind: 1, exp_ends: 0};
    vecs[4] = '{data: 16'h0000, stop_at: 8,  kind: 2, exp_ends: 0};
    vecs[5] = '{data: 16'hFFFF, stop_at: NB, kind: 0, exp_ends: 1};
    for (int v = 0; v < 6; v++)
      transfer(vecs[v].data, vecs[v].stop_at, vecs[v].kind, vecs[v].exp_ends, "table");

    for (int r = 0; r < 8; r++) begin
      logic [NB-1:0] d;
      int            st;
      d  = NB'($urandom);
      st = int'($urandom_range(1, NB + 4));
      transfer(d, st, int'($urandom_range(0, 2)), (st >= NB) ? 1 : 0, "random");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/flash_bitstream_reader.md
FLASH_BITSTREAM_READER -- requirements
Module: flash_bitstream_reader

Interface
REQ-001 SHALL have parameter START_ADDR, default 24'hCE0000, flash byte address of the channel bitstream.
REQ-002 SHALL have parameter BITSTREAM_BITS, default 32'd31_470_496, number of data bits to stream.
REQ-003 SHALL have port clk  input  1  single system clock; all logic on its rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port prog_chan_in_progress  input  1  channel programming active; gates all commands.
REQ-006 SHALL have port store_flash_command  input  1  one-cycle pulse that loads the read command.
REQ-007 SHALL have port read_bitstream  input  1  level; high requests streaming, low aborts.
REQ-008 SHALL have port bitstream  output  1  registered serial data bit, one per clk.
REQ-009 SHALL have port end_bitstream  output  1  one-cycle pulse, coincident with the last data bit on bitstream.
REQ-010 SHALL have port spi_cs_n  output  1  flash chip select, active low.
REQ-011 SHALL have port spi_sck  output  1  equals ~clk while internal sck_en is high, else 0.
REQ-012 SHALL have port spi_mosi  output  1  command/address bit, MSB first.
REQ-013 SHALL have port spi_miso  input  1  flash data bit.
REQ-014 SHALL have port crc_out  output  32  running CRC-32 over the data bits.
REQ-015 SHALL have port crc_valid  output  1  high from end_bitstream until the next store_flash_command.

Function
REQ-016 SHALL implement states IDLE, ARMED, CMD, DATA and FINISH.
REQ-017 IDLE: on store_flash_command with prog_chan_in_progress high, SHALL load shift_reg = {8'h03, START_ADDR} and go to ARMED; otherwise the pulse is ignored.
REQ-018 ARMED: read_bitstream high at cycle 0 SHALL give spi_cs_n=0, sck_en=1 and spi_mosi=shift_reg[31] at cycle 1, entering CMD.
REQ-019 CMD: SHALL shift one bit per clk for 32 cycles (cycles 1..32); spi_mosi SHALL be held 0 after the last bit.
REQ-020 DATA: SHALL sample spi_miso on each clk from cycle 33; bitstream SHALL equal the sample one cycle later (first data bit valid at cycle 34).
REQ-021 Bit counter SHALL be 32 bits; on reaching BITSTREAM_BITS-1, end_bitstream SHALL pulse with the last bit and the block SHALL enter FINISH.
REQ-022 FINISH: spi_cs_n=1, sck_en=0; SHALL return to IDLE when read_bitstream is low.
REQ-023 read_bitstream low in CMD or DATA SHALL abort: spi_cs_n=1 next cycle, state IDLE, no end_bitstream.
REQ-024 prog_chan_in_progress low in any state other than IDLE SHALL abort identically to REQ-023.
REQ-025 store_flash_command outside IDLE SHALL be ignored.
REQ-026 bitstream SHALL be 1 whenever the block is not in DATA.

Reset
REQ-027 On reset, outputs SHALL be: spi_cs_n=1, spi_sck=0, spi_mosi=0, bitstream=1, end_bitstream=0, crc_out=32'hFFFFFFFF, crc_valid=0; state SHALL be IDLE and counters 0.
REQ-028 Reset mid-transfer SHALL deassert spi_cs_n at the next clk edge with no end_bitstream pulse.

Configuration
REQ-029 With macro BITSTREAM_CRC_EN defined, SHALL compute CRC-32 (polynomial 0x04C11DB7, init 0xFFFFFFFF, no reflection, no final XOR) one bit per DATA cycle, present it on crc_out and assert crc_valid per REQ-015.
REQ-030 Without BITSTREAM_CRC_EN, crc_out SHALL be tied to 32'h0 and crc_valid to 0; no CRC logic SHALL be synthesised.

Structure
REQ-031 A shared package SHALL hold the state encoding, the flash READ opcode 8'h03, the CRC polynomial and the CRC init value.
REQ-032 The CRC SHALL be a sub-module bitstream_crc32 (inputs: clk, reset, clear, bit_en, bit_in; output: crc), instantiated only under BITSTREAM_CRC_EN.

Verification
REQ-033 Command: START_ADDR=24'hCE0000, store pulse, then read_bitstream high -> MOSI carries 32'h03CE0000 MSB first over exactly 32 sck cycles with cs_n low.
REQ-034 Data: BITSTREAM_BITS=16, flash model returns 16'hA5C3 -> bitstream shows 1010_0101_1100_0011 from cycle 34; end_bitstream is a single pulse on the final '1'; cs_n high the next cycle.
REQ-035 Abort: read_bitstream dropped after 5 data bits -> cs_n=1 next cycle, no end_bitstream, state IDLE; a new store plus read repeats REQ-033 exactly.
REQ-036 Gating: store_flash_command with prog_chan_in_progress=0 -> no CMD phase, cs_n stays 1.
REQ-037 Reset during DATA at bit 8 -> all outputs at REQ-027 values the next cycle.
REQ-038 CRC (BITSTREAM_CRC_EN): 32 data bits 32'h00000000 -> crc_out=32'hC704DD7B with crc_valid high after end_bitstream; without the macro, crc_out=0 and crc_valid=0.
